// File: rtl/vedic16x16_seq_ctrl_pkg.sv
// Shared encodings for the sequential 16x16 Vedic multiplier controller:
// FSM state codes and the per-step partial-product shift amounts.
package vedic16x16_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [4:0] SH0  = 5'd0;
    localparam logic [4:0] SH8  = 5'd8;
    localparam logic [4:0] SH16 = 5'd16;

    // Step 0 is lo*lo, steps 1/2 are the cross terms, step 3 is hi*hi.
    function automatic logic [4:0] step_shift(input logic [1:0] step);
        logic [4:0] sh;
        case (step)
            2'd0:    sh = SH0;
            2'd1:    sh = SH8;
            2'd2:    sh = SH8;
            2'd3:    sh = SH16;
            default: sh = SH0;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/vedic16x16_seq_ctrl_vedic8x8.sv
// Purely combinational 8x8 unsigned Vedic (Urdhva Tiryagbhyam) multiplier,
// built hierarchically from 2x2 and 4x4 vertical-crosswise blocks.
module vedic8x8 (
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    output logic [15:0] p
);

    function automatic logic [3:0] vedic2x2(input logic [1:0] u, input logic [1:0] v);
        logic t1;
        logic t2;
        logic t3;
        logic c1;
        logic [3:0] r;
        t1   = u[1] & v[0];
        t2   = u[0] & v[1];
        t3   = u[1] & v[1];
        c1   = t1 & t2;
        r[0] = u[0] & v[0];
        r[1] = t1 ^ t2;
        r[2] = t3 ^ c1;
        r[3] = t3 & c1;
        return r;
    endfunction

    function automatic logic [7:0] vedic4x4(input logic [3:0] u, input logic [3:0] v);
        logic [3:0] q0;
        logic [3:0] q1;
        logic [3:0] q2;
        logic [3:0] q3;
        q0 = vedic2x2(u[1:0], v[1:0]);
        q1 = vedic2x2(u[3:2], v[1:0]);
        q2 = vedic2x2(u[1:0], v[3:2]);
        q3 = vedic2x2(u[3:2], v[3:2]);
        return {4'd0, q0} + {2'd0, q1, 2'd0} + {2'd0, q2, 2'd0} + {q3, 4'd0};
    endfunction

    logic [7:0] r0_s;
    logic [7:0] r1_s;
    logic [7:0] r2_s;
    logic [7:0] r3_s;

    // Four 4x4 crosswise products summed at their nibble offsets.
    always_comb begin
        r0_s = vedic4x4(x[3:0], y[3:0]);
        r1_s = vedic4x4(x[7:4], y[3:0]);
        r2_s = vedic4x4(x[3:0], y[7:4]);
        r3_s = vedic4x4(x[7:4], y[7:4]);
        p    = {8'd0, r0_s} + {4'd0, r1_s, 4'd0} + {4'd0, r2_s, 4'd0} + {r3_s, 8'd0};
    end

endmodule

// File: rtl/vedic16x16_seq_ctrl.sv
// Sequential 16x16 unsigned multiplier: one shared vedic8x8 is stepped over the
// four 8x8 partial products and accumulated into a 32-bit result.
module vedic16x16_seq_ctrl
    import vedic16x16_seq_ctrl_pkg::*;
#(
    parameter int TAG_W     = 4,
    parameter bit ZERO_SKIP = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      a,
    input  logic [15:0]      b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      prod,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    state_e             state_r;
    state_e             state_nxt_s;
    logic [1:0]         step_r;
    logic [15:0]        a_r;
    logic [15:0]        b_r;
    logic [TAG_W-1:0]   tag_r;
    logic [31:0]        acc_r;
    logic [31:0]        prod_r;
    logic [31:0]        acc_sum_s;
    logic [7:0]         mul_x_s;
    logic [7:0]         mul_y_s;
    logic [15:0]        pp_s;
    logic               accept_s;
    logic               zero_hit_s;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               busy_r;
    logic               in_ready_nxt_s;
    logic               out_valid_nxt_s;
    logic               busy_nxt_s;

    assign accept_s   = in_valid && (state_r == IDLE);
    assign zero_hit_s = (ZERO_SKIP == 1'b1) && ((a == 16'd0) || (b == 16'd0));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (zero_hit_s) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = MUL;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            MUL: begin
                if (step_r == 2'd3) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = MUL;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode from the next state so the handshake flags come straight from flops.
    always_comb begin
        in_ready_nxt_s  = 1'b0;
        out_valid_nxt_s = 1'b0;
        busy_nxt_s      = 1'b1;
        case (state_nxt_s)
            IDLE: begin
                in_ready_nxt_s = 1'b1;
                busy_nxt_s     = 1'b0;
            end
            MUL:  out_valid_nxt_s = 1'b0;
            DONE: out_valid_nxt_s = 1'b1;
            default: begin
                in_ready_nxt_s = 1'b1;
                busy_nxt_s     = 1'b0;
            end
        endcase
    end

    // Registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r  <= in_ready_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    // Step 0 lo*lo, 1 a_lo*b_hi, 2 a_hi*b_lo, 3 hi*hi.
    always_comb begin
        if (step_r[1]) begin
            mul_x_s = a_r[15:8];
        end else begin
            mul_x_s = a_r[7:0];
        end
        if (step_r[0]) begin
            mul_y_s = b_r[15:8];
        end else begin
            mul_y_s = b_r[7:0];
        end
        acc_sum_s = acc_r + ({16'd0, pp_s} << step_shift(step_r));
    end

    vedic8x8 u_vedic8x8 (
        .x (mul_x_s),
        .y (mul_y_s),
        .p (pp_s)
    );

    // Operand latch, step counter, accumulator and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= 16'd0;
            b_r    <= 16'd0;
            tag_r  <= '0;
            step_r <= 2'd0;
            acc_r  <= 32'd0;
            prod_r <= 32'd0;
        end else if (accept_s) begin
            a_r    <= a;
            b_r    <= b;
            tag_r  <= in_tag;
            step_r <= 2'd0;
            acc_r  <= 32'd0;
            if (zero_hit_s) begin
                prod_r <= 32'd0;
            end
        end else if (state_r == MUL) begin
            acc_r  <= acc_sum_s;
            step_r <= step_r + 2'd1;
            if (step_r == 2'd3) begin
                prod_r <= acc_sum_s;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign prod      = prod_r;
    assign out_tag   = tag_r;

endmodule

// File: tb/tb_vedic16x16_seq_ctrl.sv
// Directed and streaming checks for vedic16x16_seq_ctrl, with a second
// instance built without zero-skip for the latency comparison.
module tb_vedic16x16_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_valid2;
    logic        in_ready;
    logic        in_ready2;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_valid2;
    logic        out_ready;
    logic [31:0] prod;
    logic [31:0] prod2;
    logic [3:0]  out_tag;
    logic [3:0]  out_tag2;
    logic        busy;
    logic        busy2;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    vedic16x16_seq_ctrl #(.TAG_W(4), .ZERO_SKIP(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .prod(prod), .out_tag(out_tag), .busy(busy)
    );

    vedic16x16_seq_ctrl #(.TAG_W(4), .ZERO_SKIP(1'b0)) dut_nz (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a), .b(b), .in_tag(in_tag), .out_valid(out_valid2), .out_ready(out_ready),
        .prod(prod2), .out_tag(out_tag2), .busy(busy2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one operand beat to dut and hold it until accepted; returns in cycle 1.
    task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic [3:0] it);
        int g;
        g = 0;
        a = ia; b = ib; in_tag = it; in_valid = 1'b1;
        while (!in_ready && g < 50) begin
            tick();
            g++;
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 1;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b1;
        a = 16'd0; b = 16'd0; in_tag = 4'd0;
        #12;
        chk_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || prod !== 32'd0 || out_tag !== 4'd0)
            $display("FAIL reset_outputs: out_valid=%b busy=%b prod=%h tag=%h, want 0/0/0/0", out_valid, busy, prod, out_tag);
        else pass_cnt++;
        rst_n = 1'b1;
        tick();
        chk_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_basic;
        int n;
        out_ready = 1'b1;
        issue(16'h1234, 16'h5678, 4'd3);
        chk_cnt++;
        if (in_ready !== 1'b0) $display("FAIL basic_in_ready_mul: got %b want 0", in_ready);
        else pass_cnt++;
        wait_valid(n);
        chk_cnt++;
        if (n !== 5) $display("FAIL basic_latency: got %0d want 5", n);
        else pass_cnt++;
        chk_cnt++;
        if (prod !== 32'h06260060 || out_tag !== 4'd3)
            $display("FAIL basic_result: prod=%h tag=%0d want 06260060 tag=3", prod, out_tag);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL basic_return_idle: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_corners;
        int n;
        out_ready = 1'b1;
        issue(16'hFFFF, 16'hFFFF, 4'd7);
        wait_valid(n);
        chk_cnt++;
        if (prod !== 32'hFFFE0001) $display("FAIL max_operands: prod=%h want FFFE0001", prod);
        else pass_cnt++;
        tick();
        issue(16'h00FF, 16'hFF00, 4'd8);
        wait_valid(n);
        chk_cnt++;
        if (prod !== 32'h00FE0100) $display("FAIL cross_bytes: prod=%h want 00FE0100", prod);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_zero_skip;
        int v1;
        int v2;
        int busy_n;
        logic [31:0] p2;
        v1 = 0; v2 = 0; busy_n = 0; p2 = 32'hDEADBEEF;
        out_ready = 1'b1;
        a = 16'h0000; b = 16'hABCD; in_tag = 4'd2;
        in_valid = 1'b1; in_valid2 = 1'b1;
        tick();
        in_valid = 1'b0; in_valid2 = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            if (out_valid && v1 == 0) begin
                v1 = n;
                chk_cnt++;
                if (prod !== 32'd0) $display("FAIL zskip_prod: prod=%h want 0", prod);
                else pass_cnt++;
            end
            if (out_valid2 && v2 == 0) begin
                v2 = n;
                p2 = prod2;
            end
            if (busy) busy_n++;
            tick();
        end
        chk_cnt++;
        if (v1 !== 1) $display("FAIL zskip_latency: got %0d want 1", v1);
        else pass_cnt++;
        chk_cnt++;
        if (busy_n !== 1) $display("FAIL zskip_busy_cycles: got %0d want 1", busy_n);
        else pass_cnt++;
        chk_cnt++;
        if (v2 !== 5 || p2 !== 32'd0) $display("FAIL noskip_result: cycle %0d prod=%h want 5 and 0", v2, p2);
        else pass_cnt++;
    endtask

    task automatic test_backpressure;
        int n;
        int bad;
        logic [31:0] p;
        logic [3:0] t;
        bad = 0;
        out_ready = 1'b0;
        issue(16'hBEEF, 16'h0002, 4'd9);
        wait_valid(n);
        p = prod; t = out_tag;
        chk_cnt++;
        if (p !== 32'h00017DDE || t !== 4'd9) $display("FAIL bp_result: prod=%h tag=%0d want 00017DDE tag=9", p, t);
        else pass_cnt++;
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0];
            a = 16'h1111;
            tick();
            if (out_valid !== 1'b1 || prod !== p || out_tag !== t || in_ready !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        chk_cnt++;
        if (bad !== 0) $display("FAIL bp_hold: %0d unstable cycles, want 0", bad);
        else pass_cnt++;
        out_ready = 1'b1;
        tick();
        chk_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_op;
        int n;
        int seen;
        seen = 0;
        out_ready = 1'b1;
        issue(16'h1234, 16'h5678, 4'd4);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || prod !== 32'd0 || out_tag !== 4'd0)
            $display("FAIL midreset_outputs: ov=%b busy=%b ir=%b prod=%h tag=%h want 0/0/1/0/0", out_valid, busy, in_ready, prod, out_tag);
        else pass_cnt++;
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (out_valid) seen++;
        end
        chk_cnt++;
        if (seen !== 0) $display("FAIL midreset_no_result: out_valid seen %0d cycles, want 0", seen);
        else pass_cnt++;
        issue(16'h0003, 16'h0007, 4'd5);
        wait_valid(n);
        chk_cnt++;
        if (n !== 5 || prod !== 32'h00000015 || out_tag !== 4'd5)
            $display("FAIL midreset_next_op: cycle %0d prod=%h tag=%0d want 5 00000015 5", n, prod, out_tag);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_q[$];
        logic [3:0]  tag_q[$];
        int issued;
        int received;
        int cyc;
        logic took;
        issued = 0; received = 0; cyc = 0;
        in_valid = 1'b0;
        while ((issued < 200 || received < issued) && cyc < 20000) begin
            if (!in_valid && issued < 200) begin
                a = 16'($urandom);
                b = 16'($urandom);
                if ($urandom_range(0, 7) == 0) a = 16'd0;
                if ($urandom_range(0, 7) == 0) b = 16'd0;
                in_tag = issued[3:0];
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid && out_ready) begin
                chk_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL stream_extra: unexpected result prod=%h tag=%0d", prod, out_tag);
                end else begin
                    if (prod !== exp_q[0] || out_tag !== tag_q[0])
                        $display("FAIL stream_result #%0d: prod=%h tag=%0d want %h tag=%0d", received, prod, out_tag, exp_q[0], tag_q[0]);
                    else pass_cnt++;
                    void'(exp_q.pop_front());
                    void'(tag_q.pop_front());
                end
                received++;
            end
            took = in_valid && in_ready;
            if (took) begin
                exp_q.push_back({16'd0, a} * {16'd0, b});
                tag_q.push_back(in_tag);
                issued++;
            end
            tick();
            cyc++;
            if (took) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        chk_cnt++;
        if (received !== 200 || issued !== 200 || exp_q.size() != 0)
            $display("FAIL stream_count: issued=%0d received=%0d left=%0d want 200/200/0", issued, received, exp_q.size());
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_zero_skip();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
